// File: rtl/rifl_tx_arb_pkg.sv
// rtl/rifl_tx_arb_pkg.sv - shared constants and types for the RIFL TX channel arbiter
//
// Holds the 2-bit frame header encodings and the arbiter state enum.

package rifl_tx_arb_pkg;

    localparam logic [1:0] HDR_NONE = 2'b00;  // empty frame, no user data
    localparam logic [1:0] HDR_DATA = 2'b10;  // data beat, packet continues
    localparam logic [1:0] HDR_LAST = 2'b11;  // data beat, last of packet

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rifl_rr_arbiter.sv
// rtl/rifl_rr_arbiter.sv - combinational rotating-priority encoder
//
// Ports:
//   req       requests, one bit per channel
//   ptr       highest-priority channel this cycle (must be < NUM_CH)
//   gnt_valid at least one request is set
//   gnt_id    first requesting channel at or after ptr, wrapping NUM_CH-1 -> 0

module rifl_rr_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int CH_ID_WIDTH = 4
) (
    input  logic [NUM_CH-1:0]      req,
    input  logic [CH_ID_WIDTH-1:0] ptr,
    output logic                   gnt_valid,
    output logic [CH_ID_WIDTH-1:0] gnt_id
);

    int p;
    int d;
    int best_d;
    int best;

    // Each channel's distance from ptr is measured modulo NUM_CH, so the
    // wrap works for any channel count, not just powers of two. The request
    // with the smallest distance wins.
    always_comb begin
        p         = int'(ptr);
        d         = 0;
        best_d    = NUM_CH;
        best      = 0;
        gnt_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            d = (i >= p) ? (i - p) : (i + NUM_CH - p);
            if (req[i] && (d < best_d)) begin
                best_d    = d;
                best      = i;
                gnt_valid = 1'b1;
            end
        end
        gnt_id = CH_ID_WIDTH'(best);
    end

endmodule

// File: rtl/rifl_tx_arbiter.sv
// rtl/rifl_tx_arbiter.sv - packet-locked round-robin mux of user streams onto the RIFL TX payload
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   s_tdata          NUM_CH packed data words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid/s_tlast per-channel beat valid / last beat of packet
//   s_tready         per-channel beat accepted this cycle (at most one bit set)
//   ch_enable        per-channel permission to start a new packet
//   rifl_tx_ready    TX controller consumes rifl_tx_payload this cycle
//   rifl_tx_payload  {hdr, ch_id, data}; all zeros when no beat is held
//   grant_id         channel currently locked or last granted
//   locked           a packet is in progress

module rifl_tx_arbiter
    import rifl_tx_arb_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int PAYLOAD_WIDTH = 240,
    parameter int CH_ID_WIDTH   = 4,
    localparam int DATA_WIDTH   = PAYLOAD_WIDTH - CH_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]            s_tvalid,
    input  logic [NUM_CH-1:0]            s_tlast,
    output logic [NUM_CH-1:0]            s_tready,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         rifl_tx_ready,
    output logic [PAYLOAD_WIDTH+1:0]     rifl_tx_payload,
    output logic [CH_ID_WIDTH-1:0]       grant_id,
    output logic                         locked
);

    arb_state_t               state;
    arb_state_t               state_nxt;
    logic [CH_ID_WIDTH-1:0]   rr_ptr;
    logic                     arb_valid;
    logic [CH_ID_WIDTH-1:0]   arb_id;
    logic [CH_ID_WIDTH-1:0]   sel_ch;
    logic                     sel_ok;
    logic                     sel_tvalid;
    logic                     sel_tlast;
    logic [DATA_WIDTH-1:0]    sel_tdata;
    logic                     load_en;
    logic                     accept;
    logic [PAYLOAD_WIDTH+1:0] out_reg;
    logic                     out_valid;

    rifl_rr_arbiter #(
        .NUM_CH      (NUM_CH),
        .CH_ID_WIDTH (CH_ID_WIDTH)
    ) u_rr (
        .req       (s_tvalid & ch_enable),
        .ptr       (rr_ptr),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    // The output register can take a new beat when it is empty or being drained.
    assign load_en = ~out_valid | rifl_tx_ready;

    // While locked, grant_id holds the owning channel; ch_enable is ignored
    // so a packet already started always completes.
    assign sel_ch = (state == ARB_LOCKED) ? grant_id : arb_id;
    assign sel_ok = (state == ARB_LOCKED) | arb_valid;

    always_comb begin
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tdata  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ch == CH_ID_WIDTH'(i)) begin
                sel_tvalid = s_tvalid[i];
                sel_tlast  = s_tlast[i];
                sel_tdata  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (accept && !sel_tlast) state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (accept && sel_tlast)  state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ch == CH_ID_WIDTH'(i)) begin
                s_tready[i] = load_en & sel_ok;
            end
        end
        accept = load_en & sel_ok & sel_tvalid;
        locked = (state == ARB_LOCKED);
    end

    // Output beat, grant and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= '0;
            out_valid <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= accept;
            if (accept) begin
                out_reg  <= {(sel_tlast ? HDR_LAST : HDR_DATA), sel_ch, sel_tdata};
                grant_id <= sel_ch;
                if (sel_tlast) begin
                    rr_ptr <= (sel_ch == CH_ID_WIDTH'(NUM_CH - 1)) ? '0
                                                                  : sel_ch + CH_ID_WIDTH'(1);
                end
            end
        end
    end

    // Empty cycles go out as header-00 frames with all-zero content.
    assign rifl_tx_payload = out_valid ? out_reg : '0;

endmodule

// File: tb/tb_rifl_tx_arbiter.sv
// tb/tb_rifl_tx_arbiter.sv - directed self-checking bench for rifl_tx_arbiter

module tb_rifl_tx_arbiter;

    localparam int NUM_CH = 4;
    localparam int PW     = 240;
    localparam int CIW    = 4;
    localparam int DW     = PW - CIW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_CH*DW-1:0] s_tdata;
    logic [NUM_CH-1:0]  s_tvalid;
    logic [NUM_CH-1:0]  s_tlast;
    logic [NUM_CH-1:0]  s_tready;
    logic [NUM_CH-1:0]  ch_enable;
    logic               rifl_tx_ready;
    logic [PW+1:0]      rifl_tx_payload;
    logic [CIW-1:0]     grant_id;
    logic               locked;

    int total = 0;
    int bad   = 0;

    rifl_tx_arbiter #(
        .NUM_CH        (NUM_CH),
        .PAYLOAD_WIDTH (PW),
        .CH_ID_WIDTH   (CIW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .ch_enable       (ch_enable),
        .rifl_tx_ready   (rifl_tx_ready),
        .rifl_tx_payload (rifl_tx_payload),
        .grant_id        (grant_id),
        .locked          (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat(input logic [1:0] h, input int ch, input logic [DW-1:0] d);
        logic [PW+1:0] b;
        b = {h, CIW'(ch), d};
        return 256'(b);
    endfunction

    task automatic set_d(input int ch, input logic [DW-1:0] v);
        s_tdata[ch*DW +: DW] = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick;
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        s_tdata       = '0;
        s_tvalid      = '0;
        s_tlast       = '0;
        ch_enable     = 4'hF;
        rifl_tx_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("rst_payload", 256'(rifl_tx_payload), 256'(0));
        check("rst_tready",  256'(s_tready), 256'(0));
        check("rst_grant",   256'(grant_id), 256'(0));
        check("rst_locked",  256'(locked), 256'(0));

        // ch2 three-beat packet
        tick; set_d(2, 236'hD0); s_tvalid = 4'b0100; s_tlast = 4'b0000;
        @(negedge clk);
        check("t1_rdy0", 256'(s_tready), 256'(4'b0100));
        check("t1_lk0",  256'(locked), 256'(1'b0));
        tick; set_d(2, 236'hD1);
        @(negedge clk);
        check("t1_pl0",  256'(rifl_tx_payload), beat(2'b10, 2, 236'hD0));
        check("t1_lk1",  256'(locked), 256'(1'b1));
        check("t1_rdy1", 256'(s_tready), 256'(4'b0100));
        tick; set_d(2, 236'hD2); s_tlast = 4'b0100;
        @(negedge clk);
        check("t1_pl1",  256'(rifl_tx_payload), beat(2'b10, 2, 236'hD1));
        check("t1_lk2",  256'(locked), 256'(1'b1));
        tick; s_tvalid = '0; s_tlast = '0;
        @(negedge clk);
        check("t1_pl2",  256'(rifl_tx_payload), beat(2'b11, 2, 236'hD2));
        check("t1_lk3",  256'(locked), 256'(1'b0));
        check("t1_gid",  256'(grant_id), 256'(2));
        tick;
        @(negedge clk);
        check("t1_bub",  256'(rifl_tx_payload), 256'(0));

        // ch0 and ch1 start two-beat packets together
        do_reset;
        tick; set_d(0, 236'hA); set_d(1, 236'hC); s_tvalid = 4'b0011; s_tlast = 4'b0000;
        @(negedge clk);
        check("t2_rdy0", 256'(s_tready), 256'(4'b0001));
        tick; set_d(0, 236'hB); s_tlast = 4'b0001;
        @(negedge clk);
        check("t2_pla",  256'(rifl_tx_payload), beat(2'b10, 0, 236'hA));
        check("t2_rdy1", 256'(s_tready), 256'(4'b0001));
        tick; s_tvalid = 4'b0010; s_tlast = 4'b0000;
        @(negedge clk);
        check("t2_plb",  256'(rifl_tx_payload), beat(2'b11, 0, 236'hB));
        check("t2_rdy2", 256'(s_tready), 256'(4'b0010));
        tick; set_d(1, 236'hDD); s_tlast = 4'b0010;
        @(negedge clk);
        check("t2_plc",  256'(rifl_tx_payload), beat(2'b10, 1, 236'hC));
        check("t2_rdy3", 256'(s_tready), 256'(4'b0010));
        // rr_ptr must now be 2: with ch0..ch2 requesting, ch2 wins
        tick; set_d(0, 236'hE0); set_d(1, 236'hE1); set_d(2, 236'hE2);
        s_tvalid = 4'b0111; s_tlast = 4'b0111;
        @(negedge clk);
        check("t2_pld",  256'(rifl_tx_payload), beat(2'b11, 1, 236'hDD));
        check("t2_ptr2", 256'(s_tready), 256'(4'b0100));
        tick; s_tvalid = '0; s_tlast = '0;
        @(negedge clk);
        check("t2_ple",  256'(rifl_tx_payload), beat(2'b11, 2, 236'hE2));

        // ready stall mid-packet on ch1
        tick; set_d(1, 236'h70); s_tvalid = 4'b0010; s_tlast = 4'b0000;
        @(negedge clk);
        check("t3_rdy0", 256'(s_tready), 256'(4'b0010));
        tick; set_d(1, 236'h71); rifl_tx_ready = 1'b0;
        @(negedge clk);
        check("t3_hold", 256'(rifl_tx_payload), beat(2'b10, 1, 236'h70));
        check("t3_stall", 256'(s_tready), 256'(0));
        for (int k = 0; k < 4; k++) begin
            tick;
            @(negedge clk);
            check("t3_hold", 256'(rifl_tx_payload), beat(2'b10, 1, 236'h70));
            check("t3_stall", 256'(s_tready), 256'(0));
        end
        tick; rifl_tx_ready = 1'b1;
        @(negedge clk);
        check("t3_x0",   256'(rifl_tx_payload), beat(2'b10, 1, 236'h70));
        check("t3_rdy1", 256'(s_tready), 256'(4'b0010));
        tick; set_d(1, 236'h72); s_tlast = 4'b0010;
        @(negedge clk);
        check("t3_x1",   256'(rifl_tx_payload), beat(2'b10, 1, 236'h71));
        tick; s_tvalid = '0; s_tlast = '0;
        @(negedge clk);
        check("t3_x2",   256'(rifl_tx_payload), beat(2'b11, 1, 236'h72));
        tick;
        @(negedge clk);
        check("t3_bub",  256'(rifl_tx_payload), 256'(0));

        // all channels stream single-beat packets
        do_reset;
        for (int k = 0; k < 7; k++) begin
            tick;
            if (k == 0) begin
                for (int c = 0; c < NUM_CH; c++) set_d(c, DW'(236'h100 + c));
                s_tvalid = 4'hF;
                s_tlast  = 4'hF;
            end
            if (k == 6) begin
                s_tvalid = '0;
                s_tlast  = '0;
            end
            @(negedge clk);
            if (k < 6) check("t4_rdy", 256'(s_tready), 256'(4'b0001 << (k % 4)));
            if (k >= 1) check("t4_pl", 256'(rifl_tx_payload),
                              beat(2'b11, (k - 1) % 4, DW'(236'h100 + (k - 1) % 4)));
        end

        // ch_enable[1] drops mid-packet; packet still completes
        tick; set_d(1, 236'h50); s_tvalid = 4'b0010; s_tlast = 4'b0000;
        @(negedge clk);
        check("t5_rdy0", 256'(s_tready), 256'(4'b0010));
        tick; set_d(1, 236'h51); ch_enable = 4'b1101;
        @(negedge clk);
        check("t5_y0",   256'(rifl_tx_payload), beat(2'b10, 1, 236'h50));
        check("t5_rdy1", 256'(s_tready), 256'(4'b0010));
        check("t5_lk",   256'(locked), 256'(1'b1));
        tick; set_d(1, 236'h52);
        @(negedge clk);
        check("t5_y1",   256'(rifl_tx_payload), beat(2'b10, 1, 236'h51));
        check("t5_rdy2", 256'(s_tready), 256'(4'b0010));
        tick; set_d(1, 236'h53); s_tlast = 4'b0010;
        @(negedge clk);
        check("t5_y2",   256'(rifl_tx_payload), beat(2'b10, 1, 236'h52));
        check("t5_rdy3", 256'(s_tready), 256'(4'b0010));
        tick; set_d(1, 236'h5F);
        @(negedge clk);
        check("t5_y3",   256'(rifl_tx_payload), beat(2'b11, 1, 236'h53));
        check("t5_blk0", 256'(s_tready), 256'(0));
        check("t5_lk0",  256'(locked), 256'(1'b0));
        tick;
        @(negedge clk);
        check("t5_bub",  256'(rifl_tx_payload), 256'(0));
        check("t5_blk1", 256'(s_tready), 256'(0));
        tick; set_d(0, 236'h60); s_tvalid = 4'b0011; s_tlast = 4'b0011;
        @(negedge clk);
        check("t5_ch0",  256'(s_tready), 256'(4'b0001));
        tick; s_tvalid = 4'b0010; s_tlast = 4'b0010;
        @(negedge clk);
        check("t5_w",    256'(rifl_tx_payload), beat(2'b11, 0, 236'h60));
        check("t5_blk2", 256'(s_tready), 256'(0));
        tick; s_tvalid = '0; s_tlast = '0; ch_enable = 4'hF;

        // reset during the second beat of a ch0 packet
        tick; set_d(0, 236'h80); s_tvalid = 4'b0001; s_tlast = 4'b0000;
        @(negedge clk);
        check("t6_rdy0", 256'(s_tready), 256'(4'b0001));
        tick; set_d(0, 236'h81); rst = 1'b1;
        @(negedge clk);
        check("t6_p0",   256'(rifl_tx_payload), beat(2'b10, 0, 236'h80));
        check("t6_lk",   256'(locked), 256'(1'b1));
        tick; rst = 1'b0; s_tvalid = '0;
        @(negedge clk);
        check("t6_rpl",  256'(rifl_tx_payload), 256'(0));
        check("t6_rrdy", 256'(s_tready), 256'(0));
        check("t6_rlk",  256'(locked), 256'(1'b0));
        check("t6_rgid", 256'(grant_id), 256'(0));
        tick; set_d(3, 236'h93); s_tvalid = 4'b1000; s_tlast = 4'b1000;
        @(negedge clk);
        check("t6_rdy3", 256'(s_tready), 256'(4'b1000));
        tick; s_tvalid = '0; s_tlast = '0;
        @(negedge clk);
        check("t6_q",    256'(rifl_tx_payload), beat(2'b11, 3, 236'h93));
        check("t6_gid",  256'(grant_id), 256'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
